// File: rtl/uart_frame_rx_if.sv
// Signal bundle between the serial line / host logic and uart_frame_rx.
// The master drives rx and observes the decoded frame; the slave is the receiver.
interface uart_frame_rx_if;
    logic               rx;
    logic signed [63:0] po_data;
    logic               po_flag;
    logic               frame_err;

    modport master (output rx, input po_data, input po_flag, input frame_err);
    modport slave  (input rx, output po_data, output po_flag, output frame_err);
endinterface

// File: rtl/uart_frame_rx.sv
// UART receiver for the 9-byte result frame: sync byte, then 8 data bytes LSB-first.
// Rebuilds the signed 64-bit payload and pulses po_flag, or pulses frame_err on abort.
module uart_frame_rx #(
    parameter int unsigned UART_BPS     = 115200,
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter logic [7:0]  SYNC_BYTE    = 8'h17,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    uart_frame_rx_if.slave bus
);
    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned SAMPLE_PT    = BAUD_CNT_MAX / 2 - 1;
    localparam int unsigned BAUD_W       = 13;
    localparam int unsigned GAP_MAX      = TIMEOUT_BITS * BAUD_CNT_MAX;
    localparam int unsigned GAP_W        = $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic       {FR_HUNT, FR_COLLECT}                 fr_state_e;

    rx_state_e          rx_state_q, rx_state_d;
    fr_state_e          fr_state_q, fr_state_d;
    logic [2:0]         sync_q;
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [63:0]        shreg_q, shreg_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic signed [63:0] po_data_q, po_data_d;
    logic               po_flag_q, po_flag_d;
    logic               frame_err_q, frame_err_d;

    logic rx_s_c, fall_c, sample_c, byte_valid_c, stop_ok_c, timeout_c;

    assign rx_s_c    = sync_q[1];
    assign fall_c    = ~sync_q[1] & sync_q[2];
    assign sample_c  = (baud_cnt_q == BAUD_W'(SAMPLE_PT));
    assign stop_ok_c = rx_s_c;
    assign timeout_c = (fr_state_q == FR_COLLECT) && (gap_cnt_q == GAP_W'(GAP_MAX));

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q      <= 3'b111;
            rx_state_q  <= RX_IDLE;
            fr_state_q  <= FR_HUNT;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            rx_byte_q   <= '0;
            byte_idx_q  <= '0;
            shreg_q     <= '0;
            gap_cnt_q   <= '0;
            po_data_q   <= '0;
            po_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], bus.rx};
            rx_state_q  <= rx_state_d;
            fr_state_q  <= fr_state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_byte_q   <= rx_byte_d;
            byte_idx_q  <= byte_idx_d;
            shreg_q     <= shreg_d;
            gap_cnt_q   <= gap_cnt_d;
            po_data_q   <= po_data_d;
            po_flag_q   <= po_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Byte receiver next state; STOP leaves at the sample point so bytes may abut
    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RX_IDLE:  if (fall_c) rx_state_d = RX_START;
            RX_START: if (sample_c) rx_state_d = rx_s_c ? RX_IDLE : RX_DATA;
            RX_DATA:  if (sample_c && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (sample_c) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // Byte receiver datapath
    always_comb begin
        baud_cnt_d   = '0;
        bit_cnt_d    = bit_cnt_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_c = 1'b0;
        if (rx_state_q == RX_IDLE) begin
            bit_cnt_d = '0;
        end else if (baud_cnt_q != BAUD_W'(BAUD_CNT_MAX - 1)) begin
            baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
        if (sample_c && rx_state_q == RX_DATA) begin
            rx_byte_d = {rx_s_c, rx_byte_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (sample_c && rx_state_q == RX_STOP) byte_valid_c = 1'b1;
    end

    // Frame FSM next state
    always_comb begin
        fr_state_d = fr_state_q;
        unique case (fr_state_q)
            FR_HUNT:
                if (byte_valid_c && stop_ok_c && rx_byte_q == SYNC_BYTE) fr_state_d = FR_COLLECT;
            FR_COLLECT:
                if (timeout_c) fr_state_d = FR_HUNT;
                else if (byte_valid_c && (!stop_ok_c || byte_idx_q == 3'd7)) fr_state_d = FR_HUNT;
            default: fr_state_d = FR_HUNT;
        endcase
    end

    // Frame assembly, inter-byte gap timer and output pulses
    always_comb begin
        shreg_d     = shreg_q;
        byte_idx_d  = byte_idx_q;
        po_data_d   = po_data_q;
        po_flag_d   = 1'b0;
        frame_err_d = 1'b0;
        gap_cnt_d   = '0;
        if (fr_state_q == FR_COLLECT && rx_state_q == RX_IDLE && !fall_c && !timeout_c)
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (fr_state_q == FR_HUNT) begin
            byte_idx_d = '0;
        end else if (timeout_c) begin
            frame_err_d = 1'b1;
        end else if (byte_valid_c) begin
            if (stop_ok_c) begin
                shreg_d[{byte_idx_q, 3'b000} +: 8] = rx_byte_q;
                byte_idx_d = byte_idx_q + 3'd1;
                if (byte_idx_q == 3'd7) begin
                    po_data_d = $signed(shreg_d);
                    po_flag_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign bus.po_data   = po_data_q;
    assign bus.po_flag   = po_flag_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a scoreboard queue holds expected payloads, popped on po_flag.
// Baud is scaled to 16 clocks per bit so the full sequence stays short.
module tb_uart_frame_rx;
    localparam int unsigned BIT = 16;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    uart_frame_rx_if bus ();

    uart_frame_rx #(
        .UART_BPS    (100_000),
        .CLK_FREQ    (1_600_000),
        .SYNC_BYTE   (8'h17),
        .TIMEOUT_BITS(20)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          flag_cnt  = 0;
    int          err_cnt   = 0;
    int          cyc       = 0;
    int          err_cyc   = 0;
    logic [63:0] exp_q[$];

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge sys_clk) cyc++;

    // Output monitor: pops the scoreboard on every po_flag
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (bus.po_flag || bus.frame_err)
                check64("flag_err_exclusive", 64'(bus.po_flag & bus.frame_err), 64'd0);
            if (bus.po_flag) begin
                flag_cnt++;
                check64("flag_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check64("po_data", bus.po_data, exp_q.pop_front());
            end
            if (bus.frame_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        repeat (BIT) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (BIT) @(negedge sys_clk);
        end
        bus.rx = stop;
        repeat (BIT) @(negedge sys_clk);
        bus.rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        bus.rx = 1'b1;
        repeat (n * BIT) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [63:0] d);
        exp_q.push_back(d);
        send_byte(8'h17, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check64({tag, "_po_data"}, bus.po_data, 64'd0);
        check64({tag, "_po_flag"}, 64'(bus.po_flag), 64'd0);
        check64({tag, "_frame_err"}, 64'(bus.frame_err), 64'd0);
    endtask

    initial begin
        int gap;
        bus.rx = 1'b1;
        repeat (5) @(negedge sys_clk);
        check_idle_outputs("reset");
        sys_rst_n = 1'b1;
        idle_bits(2);

        // Basic frame
        send_frame(64'h0807060504030201);
        idle_bits(2);
        check64("t1_flags", 64'(flag_cnt), 64'd1);
        check64("t1_errs", 64'(err_cnt), 64'd0);

        // Junk bytes before sync, negative payload
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_frame(64'hFF00000000000080);
        idle_bits(2);
        check64("t2_flags", 64'(flag_cnt), 64'd2);
        check64("t2_sign", 64'(bus.po_data[63]), 64'd1);

        // Bad stop bit on data byte 4
        send_byte(8'h17, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        idle_bits(3);
        check64("t3_errs", 64'(err_cnt), 64'd1);
        check64("t3_flags", 64'(flag_cnt), 64'd2);
        check64("t3_po_data_held", bus.po_data, 64'hFF00000000000080);
        send_frame(64'h1122334455667788);
        idle_bits(2);
        check64("t3_recover_flags", 64'(flag_cnt), 64'd3);

        // Short glitch, then a long low pulse while idle
        bus.rx = 1'b0;
        repeat (4) @(negedge sys_clk);
        idle_bits(2);
        bus.rx = 1'b0;
        repeat (100) @(negedge sys_clk);
        idle_bits(12);
        check64("t4_flags", 64'(flag_cnt), 64'd3);
        check64("t4_errs", 64'(err_cnt), 64'd1);
        send_frame(64'hDEADBEEF01234567);
        idle_bits(2);
        check64("t4_recover_flags", 64'(flag_cnt), 64'd4);

        // Inter-byte timeout after data byte 3
        send_byte(8'h17, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        send_byte(8'hA3, 1'b1);
        gap = cyc;
        idle_bits(25);
        gap = err_cyc - gap;
        check64("t5_errs", 64'(err_cnt), 64'd2);
        check64("t5_timeout_window", 64'(gap >= 300 && gap <= 330), 64'd1);
        check64("t5_flags", 64'(flag_cnt), 64'd4);
        send_frame(64'h1717171717171717);
        idle_bits(2);
        check64("t5_sync_data_flags", 64'(flag_cnt), 64'd5);

        // Back-to-back frames, then reset in the middle of a third
        send_frame(64'h0123456789ABCDEF);
        send_frame(64'h8000000000000001);
        idle_bits(2);
        check64("t6_flags", 64'(flag_cnt), 64'd7);
        check64("t6_last_data", bus.po_data, 64'h8000000000000001);
        send_byte(8'h17, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h60 + i), 1'b1);
        bus.rx = 1'b0;
        repeat (3 * BIT) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        check_idle_outputs("t6_in_reset");
        bus.rx = 1'b1;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle_bits(12);
        check_idle_outputs("t6_after_reset");
        check64("t6_final_flags", 64'(flag_cnt), 64'd7);
        check64("t6_final_errs", 64'(err_cnt), 64'd2);
        check64("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
